// File: rtl/lif_pkg.sv
// Shared definitions for the LIF spike monitor: default result/window widths
// and the monitor FSM state encoding.
package lif_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned WIN_W_DEF = 16;
    localparam int unsigned ISI_W_DEF = 16;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_RUN
    } lif_state_e;

endpackage

// File: rtl/lif_isi_tracker.sv
// Inter-spike interval tracker for one monitoring window.
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   clear_i    restart tracking (window start / monitor idle); wins over update
//   active_i   window cycle in progress
//   spike_i    spike on this cycle
//   min_nxt_o  running minimum ISI including this cycle's spike (all-ones if <2 spikes)
module lif_isi_tracker #(
    parameter int unsigned ISI_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             active_i,
    input  logic             spike_i,
    output logic [ISI_W-1:0] min_nxt_o
);

    logic             seen_q;
    logic [ISI_W-1:0] cnt_q;
    logic [ISI_W-1:0] min_q;
    logic [ISI_W-1:0] cnt_inc;

    // cnt_q holds (cycles since last spike - 1), so cnt_q + 1 is the interval.
    always_comb begin
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + ISI_W'(1);
        min_nxt_o = min_q;
        if (active_i && spike_i && seen_q && (cnt_inc < min_q)) begin
            min_nxt_o = cnt_inc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seen_q <= 1'b0;
            cnt_q  <= '0;
            min_q  <= '1;
        end else if (clear_i) begin
            seen_q <= 1'b0;
            cnt_q  <= '0;
            min_q  <= '1;
        end else if (active_i) begin
            if (spike_i) begin
                seen_q <= 1'b1;
                cnt_q  <= '0;
                min_q  <= min_nxt_o;
            end else begin
                cnt_q  <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/lif_spike_monitor.sv
// Windowed spike-rate and minimum-ISI monitor for a LIF neuron output.
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   en_i         monitor enable; dropping it discards the partial window
//   spike_i      1-cycle spike pulse
//   win_len_i    window length in cycles (0 treated as 1), sampled at window start
//   out_ready_i  consumer ready
//   out_valid_o  result valid
//   rate_o       spikes in the finished window (saturating)
//   isi_min_o    minimum ISI in the window, all-ones if fewer than two spikes
//   overrun_o    sticky: a finished window was dropped
//   win_tick_o   high on the last cycle of each window
module lif_spike_monitor import lif_pkg::*; #(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned WIN_W = WIN_W_DEF,
    parameter int unsigned ISI_W = ISI_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             spike_i,
    input  logic [WIN_W-1:0] win_len_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [CNT_W-1:0] rate_o,
    output logic [ISI_W-1:0] isi_min_o,
    output logic             overrun_o,
    output logic             win_tick_o
);

    lif_state_e       state_q;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] spike_cnt_q;
    logic [CNT_W-1:0] spike_cnt_nxt;
    logic [WIN_W-1:0] win_len_eff;
    logic [ISI_W-1:0] isi_min_nxt;
    logic             run;
    logic             last;

    always_comb begin
        run           = (state_q == ST_RUN) && en_i;
        last          = run && (win_cnt_q == win_len_q - WIN_W'(1));
        win_len_eff   = (win_len_i == '0) ? WIN_W'(1) : win_len_i;
        spike_cnt_nxt = spike_cnt_q;
        if (spike_i && (spike_cnt_q != '1)) begin
            spike_cnt_nxt = spike_cnt_q + CNT_W'(1);
        end
    end

    assign win_tick_o = last;

    // History clears whenever no window is in progress and on each window's
    // last cycle, so the next window starts fresh with no gap.
    lif_isi_tracker #(
        .ISI_W (ISI_W)
    ) u_isi (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!run || last),
        .active_i  (run),
        .spike_i   (spike_i),
        .min_nxt_o (isi_min_nxt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            win_len_q   <= WIN_W'(1);
            win_cnt_q   <= '0;
            spike_cnt_q <= '0;
            out_valid_o <= 1'b0;
            rate_o      <= '0;
            isi_min_o   <= '0;
            overrun_o   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en_i) begin
                        state_q     <= ST_RUN;
                        win_len_q   <= win_len_eff;
                        win_cnt_q   <= '0;
                        spike_cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (!en_i) begin
                        state_q     <= ST_IDLE;
                        win_cnt_q   <= '0;
                        spike_cnt_q <= '0;
                    end else if (last) begin
                        win_len_q   <= win_len_eff;
                        win_cnt_q   <= '0;
                        spike_cnt_q <= '0;
                    end else begin
                        win_cnt_q   <= win_cnt_q + WIN_W'(1);
                        spike_cnt_q <= spike_cnt_nxt;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A pending result that is not being taken this cycle wins over a new one.
            if (last) begin
                if (out_valid_o && !out_ready_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    out_valid_o <= 1'b1;
                    rate_o      <= spike_cnt_nxt;
                    isi_min_o   <= isi_min_nxt;
                end
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Self-checking bench for lif_spike_monitor: a scoreboard of expected window
// results is filled as windows are driven and drained on each transfer.
module tb_lif_spike_monitor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        spike_i;
    logic [15:0] win_len_i;
    logic        out_ready_i;
    logic        out_valid_o;
    logic [7:0]  rate_o;
    logic [15:0] isi_min_o;
    logic        overrun_o;
    logic        win_tick_o;

    always #5 clk_i = ~clk_i;

    lif_spike_monitor #(
        .CNT_W (8),
        .WIN_W (16),
        .ISI_W (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .spike_i     (spike_i),
        .win_len_i   (win_len_i),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .rate_o      (rate_o),
        .isi_min_o   (isi_min_o),
        .overrun_o   (overrun_o),
        .win_tick_o  (win_tick_o)
    );

    typedef struct {
        logic [7:0]  rate;
        logic [15:0] isi;
    } res_t;

    res_t sb[$];
    bit   pat[$];
    res_t mon_exp;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_valid = 1'b0;
    logic prev_tick  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Output side: compare every transfer against the oldest expected result.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (out_valid_o && !prev_valid) begin
                check_eq("valid_lat", 32'(prev_tick), 32'd1);
            end
            if (out_valid_o && out_ready_i) begin
                check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    check_eq("rate", 32'(rate_o), 32'(mon_exp.rate));
                    check_eq("isi_min", 32'(isi_min_o), 32'(mon_exp.isi));
                end
            end
        end
        prev_valid <= out_valid_o;
        prev_tick  <= win_tick_o;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic build_pat(input int len, input int s0, input int s1, input int s2,
                             input bit all);
        pat.delete();
        for (int i = 0; i < len; i++) begin
            pat.push_back(all || (i == s0) || (i == s1) || (i == s2));
        end
    endtask

    task automatic start_run(input int len);
        win_len_i = 16'(len);
        en_i      = 1'b1;
        step();
    endtask

    // Drives one full window from pat; win_len_i is changed to the next
    // window's length at once, which must not affect the current window.
    task automatic drive_window(input int len, input int nxt_len, input bit push);
        int cnt  = 0;
        int prev = -1;
        int mn   = 32'hFFFF;
        win_len_i = 16'(nxt_len);
        for (int i = 0; i < len; i++) begin
            spike_i = pat[i];
            check_eq("win_tick", 32'(win_tick_o), 32'(i == len - 1));
            if (pat[i]) begin
                cnt++;
                if (prev >= 0 && (i - prev) < mn) mn = i - prev;
                prev = i;
            end
            step();
        end
        spike_i = 1'b0;
        if (push) sb.push_back('{rate: 8'((cnt > 255) ? 255 : cnt), isi: 16'(mn)});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        en_i        = 1'b0;
        spike_i     = 1'b0;
        win_len_i   = 16'd10;
        out_ready_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;
        step();
        check_eq("rst_valid", 32'(out_valid_o), 32'd0);
        check_eq("rst_rate", 32'(rate_o), 32'd0);
        check_eq("rst_isi", 32'(isi_min_o), 32'd0);
        check_eq("rst_overrun", 32'(overrun_o), 32'd0);
        check_eq("rst_tick", 32'(win_tick_o), 32'd0);

        // Back-to-back windows, ready high, including saturation and win_len 0.
        start_run(10);
        build_pat(10, 2, 5, 6, 1'b0);   drive_window(10, 8, 1'b1);
        build_pat(8, 3, -1, -1, 1'b0);  drive_window(8, 8, 1'b1);
        build_pat(8, -1, -1, -1, 1'b0); drive_window(8, 400, 1'b1);
        build_pat(400, -1, -1, -1, 1'b1); drive_window(400, 0, 1'b1);
        build_pat(1, 0, -1, -1, 1'b0);  drive_window(1, 5, 1'b1);
        build_pat(5, -1, -1, -1, 1'b0); drive_window(5, 10, 1'b1);
        en_i = 1'b0;
        step();
        step();
        wait_drain();
        check_eq("t1_idle_valid", 32'(out_valid_o), 32'd0);

        // Consumer stalled across two windows: second result dropped.
        out_ready_i = 1'b0;
        start_run(6);
        build_pat(6, 1, 3, -1, 1'b0);   drive_window(6, 6, 1'b1);
        build_pat(6, 0, -1, -1, 1'b0);  drive_window(6, 6, 1'b0);
        en_i = 1'b0;
        step();
        check_eq("ovr_valid", 32'(out_valid_o), 32'd1);
        check_eq("ovr_rate_hold", 32'(rate_o), 32'd2);
        check_eq("ovr_isi_hold", 32'(isi_min_o), 32'd2);
        check_eq("ovr_flag", 32'(overrun_o), 32'd1);
        out_ready_i = 1'b1;
        step();
        step();
        wait_drain();
        check_eq("ovr_valid_drop", 32'(out_valid_o), 32'd0);
        check_eq("ovr_sticky", 32'(overrun_o), 32'd1);

        // Enable dropped at cycle 4: partial window discarded, idle spikes ignored.
        start_run(10);
        for (int i = 0; i < 4; i++) begin
            spike_i = 1'b1;
            check_eq("abort_tick", 32'(win_tick_o), 32'd0);
            step();
        end
        en_i = 1'b0;
        step();
        step();
        check_eq("abort_tick_idle", 32'(win_tick_o), 32'd0);
        check_eq("abort_valid", 32'(out_valid_o), 32'd0);
        start_run(5);
        build_pat(5, 0, 4, -1, 1'b0);   drive_window(5, 5, 1'b1);
        en_i = 1'b0;
        step();
        wait_drain();

        // Asynchronous reset mid-window with a result pending.
        out_ready_i = 1'b0;
        start_run(4);
        build_pat(4, 0, -1, -1, 1'b0);  drive_window(4, 4, 1'b0);
        step();
        check_eq("pre_rst_valid", 32'(out_valid_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check_eq("arst_valid", 32'(out_valid_o), 32'd0);
        check_eq("arst_rate", 32'(rate_o), 32'd0);
        check_eq("arst_isi", 32'(isi_min_o), 32'd0);
        check_eq("arst_overrun", 32'(overrun_o), 32'd0);
        check_eq("arst_tick", 32'(win_tick_o), 32'd0);
        en_i = 1'b0;
        step();
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        step();
        check_eq("post_rst_valid", 32'(out_valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
